// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - SPI mode-0 serial-flash responder with a small internal byte array
// All SPI pins are synchronised and oversampled on clk; spi_clk is never used as a clock.
module spi_flash_responder #(
  parameter int MEM_AW   = 8,
  parameter int SYNC_STG = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              busy,
  output logic              mem_wr,
  output logic [MEM_AW-1:0] mem_wr_addr,
  output logic [7:0]        status
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_STAT, S_DROP, S_RDATA, S_WDATA
  } state_t;

  state_t              state;
  logic [SYNC_STG-1:0] cs_sync, sck_sync, mosi_sync, sync_ok;
  logic                cs_s, sck_s, mosi_s, sync_valid;
  logic                sck_d, sck_rise, sck_fall;
  logic [2:0]          bit_cnt;
  logic [7:0]          sh_in, sh_out, byte_in, load_byte, wr_data;
  logic [MEM_AW-1:0]   addr;
  logic                is_read, wel, wrote, armed;
  logic [7:0]          mem [0:(1<<MEM_AW)-1];

  assign cs_s       = cs_sync[SYNC_STG-1];
  assign sck_s      = sck_sync[SYNC_STG-1];
  assign mosi_s     = mosi_sync[SYNC_STG-1];
  assign sync_valid = sync_ok[SYNC_STG-1];
  assign sck_rise   = sck_s & ~sck_d;
  assign sck_fall   = ~sck_s & sck_d;
  assign byte_in    = {sh_in[6:0], mosi_s};
  assign status     = {6'b0, wel, 1'b0};
  assign load_byte  = (state == S_RDATA) ? mem[addr] : status;

  // armed blocks a new command until CS has been seen high, so a reset taken
  // with CS still low cannot start decoding in the middle of a byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync     <= '1;
      sck_sync    <= '0;
      mosi_sync   <= '0;
      sync_ok     <= '0;
      sck_d       <= 1'b0;
      state       <= S_IDLE;
      bit_cnt     <= 3'd0;
      sh_in       <= 8'h00;
      sh_out      <= 8'h00;
      addr        <= '0;
      is_read     <= 1'b0;
      wel         <= 1'b0;
      wrote       <= 1'b0;
      armed       <= 1'b0;
      spi_miso    <= 1'b0;
      busy        <= 1'b0;
      mem_wr      <= 1'b0;
      mem_wr_addr <= '0;
      wr_data     <= 8'h00;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STG-2:0], spi_cs_n};
      sck_sync  <= {sck_sync[SYNC_STG-2:0], spi_clk};
      mosi_sync <= {mosi_sync[SYNC_STG-2:0], spi_mosi};
      sync_ok   <= {sync_ok[SYNC_STG-2:0], 1'b1};
      sck_d     <= sck_s;
      mem_wr    <= 1'b0;
      busy      <= sync_valid & ~cs_s;
      if (sync_valid && cs_s) armed <= 1'b1;

      if (cs_s || !sync_valid) begin
        if (wrote) wel <= 1'b0;
        wrote    <= 1'b0;
        state    <= S_IDLE;
        bit_cnt  <= 3'd0;
        spi_miso <= 1'b0;
      end else if (state == S_IDLE) begin
        if (armed) begin
          state   <= S_CMD;
          bit_cnt <= 3'd0;
          wrote   <= 1'b0;
          armed   <= 1'b0;
        end
      end else if (state != S_DROP) begin
        if (sck_rise) begin
          sh_in   <= byte_in;
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            case (state)
              S_CMD: begin
                case (byte_in)
                  8'h03: begin is_read <= 1'b1; state <= S_ADDR; end
                  8'h02: begin is_read <= 1'b0; state <= wel ? S_ADDR : S_DROP; end
                  8'h06: begin wel <= 1'b1; state <= S_DROP; end
                  8'h04: begin wel <= 1'b0; state <= S_DROP; end
                  8'h05: state <= S_STAT;
                  default: state <= S_DROP;
                endcase
              end
              S_ADDR: begin
                addr  <= byte_in[MEM_AW-1:0];
                state <= is_read ? S_RDATA : S_WDATA;
              end
              S_WDATA: begin
                mem_wr      <= 1'b1;
                mem_wr_addr <= addr;
                wr_data     <= byte_in;
                addr        <= addr + 1'b1;
                wrote       <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        // A fall at a byte boundary loads the next outgoing byte and drives its MSB.
        if (sck_fall && (state == S_RDATA || state == S_STAT)) begin
          if (bit_cnt == 3'd0) begin
            spi_miso <= load_byte[7];
            sh_out   <= {load_byte[6:0], 1'b0};
            if (state == S_RDATA) addr <= addr + 1'b1;
          end else begin
            spi_miso <= sh_out[7];
            sh_out   <= {sh_out[6:0], 1'b0};
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_wr) mem[mem_wr_addr] <= wr_data;
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - table-driven and randomized bench for spi_flash_responder
module tb_spi_flash_responder;
  typedef logic [7:0] byte_t;
  typedef struct {
    byte_t b[4];
    int    n;
    byte_t rx[4];
    int    nw;
    byte_t wa0;
    byte_t st;
  } vec_t;

  localparam int HALF = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, busy, mem_wr;
  logic [7:0] mem_wr_addr, status;

  spi_flash_responder #(.MEM_AW(8), .SYNC_STG(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .busy(busy), .mem_wr(mem_wr),
    .mem_wr_addr(mem_wr_addr), .status(status)
  );

  always #5 clk = ~clk;

  int    n_chk = 0;
  int    n_fail = 0;
  byte_t txb[12];
  byte_t rxb[12];
  byte_t exp_rx[12];
  byte_t wq[$];
  byte_t exp_wq[$];
  byte_t m_mem[256];
  logic  m_wel = 1'b0;
  vec_t  tbl[12];

  always @(negedge clk) if (mem_wr) wq.push_back(mem_wr_addr);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: whole-transaction behaviour from the command rules.
  task automatic model_txn(input int n);
    byte_t a;
    for (int i = 0; i < 12; i++) exp_rx[i] = 8'h00;
    exp_wq.delete();
    case (txb[0])
      8'h06: m_wel = 1'b1;
      8'h04: m_wel = 1'b0;
      8'h05: for (int i = 1; i < n; i++) exp_rx[i] = {6'b0, m_wel, 1'b0};
      8'h03: if (n >= 2) begin
        a = txb[1];
        for (int i = 2; i < n; i++) begin exp_rx[i] = m_mem[a]; a++; end
      end
      8'h02: if (m_wel && n >= 2) begin
        a = txb[1];
        for (int i = 2; i < n; i++) begin m_mem[a] = txb[i]; exp_wq.push_back(a); a++; end
        if (n > 2) m_wel = 1'b0;
      end
      default: ;
    endcase
  endtask

  task automatic spi_bit(input logic b, output logic r);
    spi_mosi = b;
    repeat (HALF) @(negedge clk);
    r = spi_miso;
    spi_clk = 1'b1;
    repeat (HALF) @(negedge clk);
    spi_clk = 1'b0;
  endtask

  task automatic txn(input int n, input int pbits, input bit do_rst);
    logic r;
    spi_cs_n = 1'b0;
    repeat (HALF) @(negedge clk);
    chk("busy_in_txn", busy, 1'b1);
    for (int b = 0; b < n; b++)
      for (int i = 7; i >= 0; i--) begin spi_bit(txb[b][i], r); rxb[b][i] = r; end
    for (int i = 0; i < pbits; i++) spi_bit(txb[n][7-i], r);
    if (do_rst) begin
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      m_wel = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_model(input string tag, input int n);
    for (int i = 0; i < n; i++) chk({tag, "_miso"}, rxb[i], exp_rx[i]);
    chk({tag, "_nwr"}, wq.size(), exp_wq.size());
    for (int i = 0; i < wq.size() && i < exp_wq.size(); i++) chk({tag, "_wraddr"}, wq[i], exp_wq[i]);
    chk({tag, "_status"}, status, {6'b0, m_wel, 1'b0});
    wq.delete();
  endtask

  initial begin
    tbl[0]  = '{'{8'h06, 8'h00, 8'h00, 8'h00}, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'h00, 8'h02};
    tbl[1]  = '{'{8'h05, 8'h00, 8'h00, 8'h00}, 2, '{8'h00, 8'h02, 8'h00, 8'h00}, 0, 8'h00, 8'h02};
    tbl[2]  = '{'{8'h02, 8'h10, 8'hAA, 8'h55}, 4, '{8'h00, 8'h00, 8'h00, 8'h00}, 2, 8'h10, 8'h00};
    tbl[3]  = '{'{8'h03, 8'h10, 8'h00, 8'h00}, 4, '{8'h00, 8'h00, 8'hAA, 8'h55}, 0, 8'h00, 8'h00};
    tbl[4]  = '{'{8'h02, 8'h10, 8'h77, 8'h00}, 3, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'h00, 8'h00};
    tbl[5]  = '{'{8'h03, 8'h10, 8'h00, 8'h00}, 3, '{8'h00, 8'h00, 8'hAA, 8'h00}, 0, 8'h00, 8'h00};
    tbl[6]  = '{'{8'h06, 8'h00, 8'h00, 8'h00}, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'h00, 8'h02};
    tbl[7]  = '{'{8'h02, 8'hFF, 8'h11, 8'h22}, 4, '{8'h00, 8'h00, 8'h00, 8'h00}, 2, 8'hFF, 8'h00};
    tbl[8]  = '{'{8'h03, 8'hFF, 8'h00, 8'h00}, 4, '{8'h00, 8'h00, 8'h11, 8'h22}, 0, 8'h00, 8'h00};
    tbl[9]  = '{'{8'h06, 8'h00, 8'h00, 8'h00}, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'h00, 8'h02};
    tbl[10] = '{'{8'h04, 8'h00, 8'h00, 8'h00}, 1, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'h00, 8'h00};
    tbl[11] = '{'{8'h05, 8'h00, 8'h00, 8'h00}, 3, '{8'h00, 8'h00, 8'h00, 8'h00}, 0, 8'h00, 8'h00};

    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("reset_miso", spi_miso, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_mem_wr", mem_wr, 1'b0);
    chk("reset_status", status, 8'h00);

    for (int v = 0; v < 12; v++) begin
      for (int i = 0; i < 4; i++) txb[i] = tbl[v].b[i];
      model_txn(tbl[v].n);
      txn(tbl[v].n, 0, 1'b0);
      for (int i = 0; i < tbl[v].n; i++) chk($sformatf("vec%0d_miso%0d", v, i), rxb[i], tbl[v].rx[i]);
      chk($sformatf("vec%0d_nwr", v), wq.size(), tbl[v].nw);
      for (int i = 0; i < wq.size(); i++) chk($sformatf("vec%0d_wraddr", v), wq[i], byte_t'(tbl[v].wa0 + i));
      chk($sformatf("vec%0d_status", v), status, tbl[v].st);
      wq.delete();
    end

    // Partial data byte after a program: nothing written, WEL kept.
    txb[0] = 8'h06; model_txn(1); txn(1, 0, 1'b0); check_model("p_wren", 1);
    txb[0] = 8'h02; txb[1] = 8'h20; txb[2] = 8'hAB;
    model_txn(2); txn(2, 5, 1'b0); check_model("p_partial", 2);
    txb[0] = 8'h05; txb[1] = 8'h00; model_txn(2); txn(2, 0, 1'b0); check_model("p_rdsr", 2);

    // Preload a window for the random phase.
    txb[0] = 8'h06; model_txn(1); txn(1, 0, 1'b0); check_model("init_wren", 1);
    txb[0] = 8'h02; txb[1] = 8'h40;
    for (int i = 2; i < 10; i++) txb[i] = byte_t'($urandom);
    model_txn(10); txn(10, 0, 1'b0); check_model("init_prog", 10);

    // Reset pulsed mid-READ, then a fresh command decodes cleanly.
    txb[0] = 8'h06; model_txn(1); txn(1, 0, 1'b0); check_model("r_wren", 1);
    txb[0] = 8'h03; txb[1] = 8'h40; txb[2] = 8'h00;
    model_txn(2); txn(2, 3, 1'b1);
    chk("r_nwr", wq.size(), 0);
    chk("r_status", status, 8'h00);
    wq.delete();
    txb[0] = 8'h03; txb[1] = 8'h41; txb[2] = 8'h00; txb[3] = 8'h00;
    model_txn(4); txn(4, 0, 1'b0); check_model("r_read", 4);

    for (int t = 0; t < 30; t++) begin
      byte_t ops[8];
      int    n, pb;
      ops = '{8'h03, 8'h03, 8'h02, 8'h06, 8'h06, 8'h04, 8'h05, 8'h9F};
      txb[0] = ops[$urandom_range(0, 7)];
      txb[1] = byte_t'(8'h40 + $urandom_range(0, 4));
      for (int i = 2; i < 6; i++) txb[i] = byte_t'($urandom);
      n  = $urandom_range(1, 5);
      pb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      model_txn(n);
      txn(n, pb, 1'b0);
      check_model($sformatf("rnd%0d", t), n);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
